// File: rtl/rv32i_rd_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_rd_wr_arbiter_pkg
//  Purpose  : Shared sizing constants, requester indices, buffer entry type
//             and a width helper for the rd write-port arbiter.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package rv32i_rd_wr_arbiter_pkg;

  // Default arbiter configuration
  localparam int RD_ARB_NUM_REQ      = 2;
  localparam int RD_ARB_STARVE_LIMIT = 4;

  // Requester slot assignment on the late-result side
  localparam int RD_REQ_MULDIV = 0;
  localparam int RD_REQ_LOAD   = 1;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // One late result waiting for the register write port
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } rd_entry_t;

  // Index width that never collapses to zero bits
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_rr_arbiter
//  Purpose  : Round-robin picker. Grants the lowest requesting index at or
//             after ptr_i, wrapping circularly.
//  Ports    : req_i       - request vector
//             ptr_i       - search start index (must be < N)
//             gnt_o       - one-hot grant
//             gnt_valid_o - some request was granted
//  Revision : 1.0 - initial release
// ============================================================================
module rv32i_rr_arbiter
  import rv32i_rd_wr_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic             gnt_valid_o
);

  localparam logic [PTR_W:0] N_W = (PTR_W+1)'(N);

  always_comb begin
    logic [PTR_W:0] pos;
    logic           found;
    gnt_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      // ptr_i + i is below 2N, so a single subtraction implements the wrap
      pos = {1'b0, ptr_i} + (PTR_W+1)'(i);
      if (pos >= N_W) begin
        pos = pos - N_W;
      end
      if (!found && req_i[pos[PTR_W-1:0]]) begin
        gnt_o[pos[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
    gnt_valid_o = found;
  end

endmodule
`default_nettype wire

// File: rtl/rv32i_rd_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_rd_wr_arbiter
//  Purpose  : Shares the base-register write port between the in-order
//             writeback stage and NUM_REQ late-result requesters, each with a
//             one-entry holding buffer. Writeback has priority; a starvation
//             guard stalls the pipeline for one cycle so buffered results
//             always retire. Exports a pending-destination scoreboard.
//  Ports    : i_clk, i_rst_n (sync, active-low)
//             i_wb_wr_rd / i_wb_rd_addr / i_wb_rd   - writeback write request
//             i_req_valid / i_req_addr / i_req_data - late requesters (packed)
//             o_req_ready                           - requester buffer empty
//             o_wr_rd / o_rd_addr / o_rd            - register file write port
//             o_stall                               - writeback port withheld
//             o_pending                             - destinations in buffers
//  Revision : 1.0 - initial release
// ============================================================================
module rv32i_rd_wr_arbiter
  import rv32i_rd_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = RD_ARB_NUM_REQ,
  parameter int STARVE_LIMIT = RD_ARB_STARVE_LIMIT
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_wb_wr_rd,
  input  logic [REG_AW-1:0]         i_wb_rd_addr,
  input  logic [XLEN-1:0]           i_wb_rd,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [REG_AW*NUM_REQ-1:0] i_req_addr,
  input  logic [XLEN*NUM_REQ-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_wr_rd,
  output logic [REG_AW-1:0]         o_rd_addr,
  output logic [XLEN-1:0]           o_rd,
  output logic                      o_stall,
  output logic [31:0]               o_pending
);

  localparam int PTR_W = clog2_min1(NUM_REQ);
  localparam int CNT_W = clog2_min1(STARVE_LIMIT);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(STARVE_LIMIT - 1);

  rd_entry_t [NUM_REQ-1:0] buf_q, buf_d;
  logic [NUM_REQ-1:0]      buf_valid_q, buf_valid_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic                    stall_q, stall_d;

  logic                    wb_owns;
  logic [NUM_REQ-1:0]      arb_req;
  logic [NUM_REQ-1:0]      gnt;
  logic                    gnt_valid;
  logic [PTR_W-1:0]        gnt_idx;
  rd_entry_t               gnt_entry;

  // During a stall cycle the writeback request is ignored entirely
  assign wb_owns = !stall_q && i_wb_wr_rd;
  assign arb_req = wb_owns ? {NUM_REQ{1'b0}} : buf_valid_q;

  rv32i_rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i       (arb_req),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    gnt_idx   = '0;
    gnt_entry = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        gnt_idx   = PTR_W'(k);
        gnt_entry = buf_q[k];
      end
    end
  end

  // Write port mux and handshake outputs; everything is quiet during reset
  always_comb begin
    o_wr_rd     = 1'b0;
    o_rd_addr   = '0;
    o_rd        = '0;
    o_pending   = '0;
    o_req_ready = '0;
    if (i_rst_n) begin
      o_req_ready = ~buf_valid_q;
      if (wb_owns) begin
        o_wr_rd   = |i_wb_rd_addr;
        o_rd_addr = i_wb_rd_addr;
        o_rd      = i_wb_rd;
      end else if (gnt_valid) begin
        // x0 entries still retire, they just never raise the write enable
        o_wr_rd   = |gnt_entry.addr;
        o_rd_addr = gnt_entry.addr;
        o_rd      = gnt_entry.data;
      end
      // A granted entry stays visible in its write cycle: the register file
      // only holds the new value after the closing edge.
      for (int k = 0; k < NUM_REQ; k++) begin
        if (buf_valid_q[k]) begin
          o_pending[buf_q[k].addr] = 1'b1;
        end
      end
      o_pending[0] = 1'b0;
    end
  end

  assign o_stall = stall_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    rr_ptr_d    = rr_ptr_q;
    wait_cnt_d  = wait_cnt_q;
    stall_d     = 1'b0;

    // Load only into an empty buffer and grant only a full one, so the two
    // updates below never hit the same slot in one cycle.
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        buf_valid_d[k] = 1'b0;
      end
      if (i_req_valid[k] && !buf_valid_q[k]) begin
        buf_valid_d[k]    = 1'b1;
        buf_d[k].addr     = i_req_addr[REG_AW*k +: REG_AW];
        buf_d[k].data     = i_req_data[XLEN*k +: XLEN];
      end
    end

    if (gnt_valid) begin
      rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
    end

    // The counter parks at its limit; the stall it triggers forces a grant
    // next cycle, which clears it.
    if (gnt_valid || !(|buf_valid_q)) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q == CNT_LIM) begin
      stall_d = 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      buf_q       <= '0;
      buf_valid_q <= '0;
      rr_ptr_q    <= '0;
      wait_cnt_q  <= '0;
      stall_q     <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_q     <= stall_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_rd_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32i_rd_wr_arbiter
//  Purpose  : Self-checking bench for rv32i_rd_wr_arbiter: directed cases
//             followed by random writeback/requester traffic scored against
//             a queue of outstanding writes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_rd_wr_arbiter;
  import rv32i_rd_wr_arbiter_pkg::*;

  localparam int NUM_REQ      = 2;
  localparam int STARVE_LIMIT = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                wb_wr = 1'b0;
  logic [4:0]          wb_addr = '0;
  logic [31:0]         wb_data = '0;
  logic [NUM_REQ-1:0]  req_valid = '0;
  logic [5*NUM_REQ-1:0]  req_addr = '0;
  logic [32*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]  o_req_ready;
  logic                o_wr_rd;
  logic [4:0]          o_rd_addr;
  logic [31:0]         o_rd;
  logic                o_stall;
  logic [31:0]         o_pending;

  int checks = 0;
  int errors = 0;

  // Outstanding writes: accepted requester results still in their buffer,
  // plus the writeback write of the current cycle. Data words are unique
  // (tag nibble + sequence number) so a write identifies its own entry.
  rd_entry_t          exp_q[$];
  logic               mon_en = 1'b0;
  logic               prev_stall = 1'b0;
  logic [NUM_REQ-1:0] acc = '0;
  logic               wb_hold = 1'b0;
  int                 seq = 0;

  rv32i_rd_wr_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_wb_wr_rd   (wb_wr),
    .i_wb_rd_addr (wb_addr),
    .i_wb_rd      (wb_data),
    .i_req_valid  (req_valid),
    .i_req_addr   (req_addr),
    .i_req_data   (req_data),
    .o_req_ready  (o_req_ready),
    .o_wr_rd      (o_wr_rd),
    .o_rd_addr    (o_rd_addr),
    .o_rd         (o_rd),
    .o_stall      (o_stall),
    .o_pending    (o_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[k]        = v;
    req_addr[5*k +: 5]  = a;
    req_data[32*k +: 32] = d;
  endtask

  // Monitor: scores every write the DUT presents against the outstanding set
  always @(negedge clk) begin
    logic [31:0] pend;
    int          hit;
    if (mon_en) begin
      pend = '0;
      foreach (exp_q[i]) begin
        if (exp_q[i].data[31:28] != 4'hA) pend[exp_q[i].addr] = 1'b1;
      end
      pend[0] = 1'b0;
      check("pending", o_pending, pend);
      if (o_stall) check("stall_run", 32'(prev_stall), 32'd0);
      if (wb_wr && !o_stall) begin
        check("wb_wr_en", 32'(o_wr_rd), 32'(wb_addr != 5'd0));
        if (wb_addr != 5'd0) begin
          check("wb_addr", 32'(o_rd_addr), 32'(wb_addr));
          check("wb_data", o_rd, wb_data);
          check("raw_order", 32'(o_pending[wb_addr]), 32'd0);
        end
      end
      if (o_wr_rd) begin
        hit = -1;
        foreach (exp_q[i]) begin
          if (hit < 0 && exp_q[i].data == o_rd) hit = i;
        end
        if (hit < 0) begin
          checks++;
          errors++;
          $display("FAIL write_unexpected actual addr=%0d data=%h required=none", o_rd_addr, o_rd);
        end else begin
          check("write_addr", 32'(o_rd_addr), 32'(exp_q[hit].addr));
          exp_q.delete(hit);
        end
      end
      prev_stall = o_stall;
    end
  end

  // Two requesters buffered together with an idle port
  task automatic pair(input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1, input bit r1_first);
    step();
    set_req(0, 1'b1, a0, d0);
    set_req(1, 1'b1, a1, d1);
    sample();
    check("pair_ready", 32'(o_req_ready), 32'd3);
    step();
    set_req(0, 1'b0, 5'd0, 32'd0);
    set_req(1, 1'b0, 5'd0, 32'd0);
    sample();
    check("pair_first_addr", 32'(o_rd_addr), r1_first ? 32'(a1) : 32'(a0));
    check("pair_first_data", o_rd, r1_first ? d1 : d0);
    step();
    sample();
    check("pair_second_addr", 32'(o_rd_addr), r1_first ? 32'(a0) : 32'(a1));
    check("pair_second_data", o_rd, r1_first ? d0 : d1);
    step();
    sample();
    check("pair_idle", 32'(o_wr_rd), 32'd0);
  endtask

  // One random-traffic cycle; stim=0 only finishes what is already in flight
  task automatic rand_cycle(input bit stim);
    int r;
    step();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (acc[k] && req_addr[5*k +: 5] != 5'd0)
        exp_q.push_back('{addr: req_addr[5*k +: 5], data: req_data[32*k +: 32]});
    end
    if (!wb_hold) begin
      if (stim && $urandom_range(99, 0) < 70) begin
        wb_wr   = 1'b1;
        wb_addr = 5'($urandom_range(15, 0));
        wb_data = {4'hA, 28'(seq)};
        seq++;
      end else begin
        wb_wr = 1'b0;
      end
    end
    // A stalled writeback is re-presented unchanged next cycle
    if (o_stall) begin
      wb_hold = wb_wr;
    end else begin
      wb_hold = 1'b0;
      if (wb_wr && wb_addr != 5'd0) exp_q.push_back('{addr: wb_addr, data: wb_data});
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!req_valid[k] || acc[k]) begin
        if (stim && $urandom_range(99, 0) < 40) begin
          r = $urandom_range(16, 0);
          set_req(k, 1'b1, (r == 0) ? 5'd0 : 5'(r + 15), {4'(k), 28'(seq)});
          seq++;
        end else begin
          set_req(k, 1'b0, 5'd0, 32'd0);
        end
      end
    end
    sample();
    acc = req_valid & o_req_ready;
  endtask

  initial begin
    int guard;

    // ---- reset state
    repeat (3) step();
    sample();
    check("rst_ready", 32'(o_req_ready), 32'd0);
    check("rst_wr", 32'(o_wr_rd), 32'd0);
    step();
    rst_n = 1'b1;
    sample();
    check("post_rst_stall", 32'(o_stall), 32'd0);
    check("post_rst_ready", 32'(o_req_ready), 32'd3);
    check("post_rst_pending", o_pending, 32'd0);

    // ---- single late result, minimum latency
    step();
    set_req(RD_REQ_MULDIV, 1'b1, 5'd5, 32'hDEADBEEF);
    sample();
    check("t1_ready_before", 32'(o_req_ready[0]), 32'd1);
    step();
    set_req(RD_REQ_MULDIV, 1'b0, 5'd0, 32'd0);
    sample();
    check("t1_ready_busy", 32'(o_req_ready[0]), 32'd0);
    check("t1_wr", 32'(o_wr_rd), 32'd1);
    check("t1_addr", 32'(o_rd_addr), 32'd5);
    check("t1_data", o_rd, 32'hDEADBEEF);
    check("t1_pending", o_pending, 32'h0000_0020);
    step();
    sample();
    check("t1_ready_after", 32'(o_req_ready[0]), 32'd1);
    check("t1_idle", 32'(o_wr_rd), 32'd0);
    check("t1_pending_clr", o_pending, 32'd0);

    // ---- starvation: writeback busy every cycle, req1 holds r7
    step();
    wb_wr = 1'b1; wb_addr = 5'd9; wb_data = 32'hA000_0100;
    set_req(RD_REQ_LOAD, 1'b1, 5'd7, 32'hC0FFEE07);
    sample();
    check("t2_wb_first", 32'(o_rd_addr), 32'd9);
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) set_req(RD_REQ_LOAD, 1'b0, 5'd0, 32'd0);
      wb_data = 32'hA000_0100 + 32'(c);
      sample();
      check("t2_stall", 32'(o_stall), 32'(c == 5));
      if (c < 5) begin
        check("t2_wb_data", o_rd, 32'hA000_0100 + 32'(c));
        check("t2_pending7", 32'(o_pending[7]), 32'd1);
      end else begin
        check("t2_buf_addr", 32'(o_rd_addr), 32'd7);
        check("t2_buf_data", o_rd, 32'hC0FFEE07);
      end
    end
    step();
    sample();
    check("t2_represent_stall", 32'(o_stall), 32'd0);
    check("t2_represent_addr", 32'(o_rd_addr), 32'd9);
    check("t2_represent_data", o_rd, 32'hA000_0105);
    step();
    wb_wr = 1'b0;
    sample();
    check("t2_idle", 32'(o_wr_rd), 32'd0);

    // ---- round robin: req0 first, then move the pointer and req1 first
    pair(5'd3, 32'h0000_0D03, 5'd4, 32'h0000_0D04, 1'b0);
    step();
    set_req(0, 1'b1, 5'd6, 32'h0000_0D06);
    step();
    set_req(0, 1'b0, 5'd0, 32'd0);
    sample();
    check("t3_single_addr", 32'(o_rd_addr), 32'd6);
    step();
    pair(5'd10, 32'h0000_0D10, 5'd11, 32'h0000_0D11, 1'b1);

    // ---- x0 handling
    step();
    set_req(0, 1'b1, 5'd0, 32'h1234_5678);
    step();
    set_req(0, 1'b0, 5'd0, 32'd0);
    sample();
    check("t4_x0_wr", 32'(o_wr_rd), 32'd0);
    check("t4_x0_busy", 32'(o_req_ready[0]), 32'd0);
    step();
    sample();
    check("t4_x0_ready", 32'(o_req_ready[0]), 32'd1);
    step();
    wb_wr = 1'b1; wb_addr = 5'd0; wb_data = 32'hA000_0200;
    sample();
    check("t4_wb_x0", 32'(o_wr_rd), 32'd0);

    // ---- reset with both buffers holding results
    step();
    wb_addr = 5'd12; wb_data = 32'hA000_0300;
    set_req(0, 1'b1, 5'd20, 32'h0000_0E20);
    set_req(1, 1'b1, 5'd21, 32'h0000_0E21);
    sample();
    check("t5_wb", 32'(o_rd_addr), 32'd12);
    step();
    set_req(0, 1'b0, 5'd0, 32'd0);
    set_req(1, 1'b0, 5'd0, 32'd0);
    wb_data = 32'hA000_0301;
    rst_n = 1'b0;
    sample();
    check("t5_rst_wr", 32'(o_wr_rd), 32'd0);
    check("t5_rst_pending", o_pending, 32'd0);
    check("t5_rst_ready", 32'(o_req_ready), 32'd0);
    step();
    rst_n = 1'b1;
    wb_wr = 1'b0;
    sample();
    check("t5_rel_ready", 32'(o_req_ready), 32'd3);
    check("t5_rel_pending", o_pending, 32'd0);
    check("t5_rel_wr", 32'(o_wr_rd), 32'd0);
    step();
    sample();
    check("t5_no_late_wr", 32'(o_wr_rd), 32'd0);

    // ---- random traffic
    prev_stall = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
    guard = 0;
    while ((exp_q.size() != 0 || wb_hold || req_valid != '0) && guard < 200) begin
      rand_cycle(1'b0);
      guard++;
    end
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
